datacache_l1_param: RTL and testbench

DATACACHE_L1_PARAM -- requirements
Module: datacache_l1_param

---
 rtl/datacache_l1_param.sv | 334 +++++++++++++++++++++++++++++++++
 tb/tb_datacache_l1_param.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datacache_l1_param.sv
`default_nettype none
// datacache_l1_param: set-associative L1 data-cache tag/MESI/LRU controller with L2 messaging (rev 1.0).
// Optional build macro CACHE_STATS_EN adds 32-bit hits/misses/reads/writes counter outputs.
module datacache_l1_param #(
  parameter int WAYS   = 8,
  parameter int SETS   = 16384,
  parameter int ADDR_W = 60
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [2:0]                       cmd,
  input  logic [ADDR_W-1:0]                addr,
  output logic                             l2_valid,
  output logic [1:0]                       l2_cmd,
  output logic [ADDR_W-1:0]                l2_addr,
  output logic                             resp_valid,
  output logic                             resp_hit,
  input  logic [$clog2(SETS)-1:0]          dump_set,
  input  logic [3:0]                       dump_way,
  output logic [ADDR_W-$clog2(SETS)-1:0]   dump_line
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]                      hits,
  output logic [31:0]                      misses,
  output logic [31:0]                      reads,
  output logic [31:0]                      writes
`endif
);

  localparam int OFF_W  = 6;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int WAY_W  = $clog2(WAYS);
  localparam int LINE_W = ADDR_W - OFF_W;
  localparam int DUMP_W = TAG_W + 6;

  localparam logic [2:0] CMD_READ  = 3'd0;
  localparam logic [2:0] CMD_WRITE = 3'd1;
  localparam logic [2:0] CMD_INV   = 3'd2;
  localparam logic [2:0] CMD_CLEAR = 3'd3;
  localparam logic [2:0] CMD_SNOOP = 3'd4;

  localparam logic [1:0] L2_RETURNDATA = 2'd0;
  localparam logic [1:0] L2_WRITE      = 2'd1;
  localparam logic [1:0] L2_READ       = 2'd2;
  localparam logic [1:0] L2_RFO        = 2'd3;

  localparam logic [1:0] MESI_I = 2'd0;
  localparam logic [1:0] MESI_M = 2'd1;
  localparam logic [1:0] MESI_S = 2'd2;
  localparam logic [1:0] MESI_E = 2'd3;

  typedef enum logic [2:0] {IDLE, LOOKUP, UPDATE, L2_2ND, SWEEP} state_e;

  state_e             state_q, state_d;
  logic [2:0]         cmd_q;
  logic [LINE_W-1:0]  line_q;
  logic               hit_q;
  logic               vict_dirty_q;
  logic               clear_q;
  logic [WAY_W-1:0]   way_q;
  logic [1:0]         old_mesi_q;
  logic [TAG_W-1:0]   vict_tag_q;
  logic [IDX_W-1:0]   sweep_idx_q;
  logic [DUMP_W-1:0]  dump_line_q;

  logic [TAG_W-1:0]   tag_arr_q  [SETS][WAYS];
  logic [1:0]         mesi_arr_q [SETS][WAYS];
  logic [WAY_W-1:0]   lru_arr_q  [SETS][WAYS];

  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   line_tag;
  logic               unused_offset;

  assign idx           = line_q[IDX_W-1:0];
  assign line_tag      = line_q[LINE_W-1:IDX_W];
  assign unused_offset = ^addr[OFF_W-1:0];

  logic [TAG_W-1:0]   cur_tag  [WAYS];
  logic [1:0]         cur_mesi [WAYS];
  logic [WAY_W-1:0]   cur_lru  [WAYS];

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      cur_tag[w]  = tag_arr_q[idx][w];
      cur_mesi[w] = mesi_arr_q[idx][w];
      cur_lru[w]  = lru_arr_q[idx][w];
    end
  end

  // Hit and victim selection; descending scans leave the lowest matching way selected.
  logic               lk_hit;
  logic               lk_inv_found;
  logic [WAY_W-1:0]   lk_hit_way;
  logic [WAY_W-1:0]   lk_vict;
  logic [WAY_W-1:0]   lk_lru_way;
  logic [WAY_W-1:0]   lk_best_rank;

  always_comb begin
    lk_hit       = 1'b0;
    lk_hit_way   = '0;
    lk_inv_found = 1'b0;
    lk_vict      = '0;
    lk_lru_way   = '0;
    lk_best_rank = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (cur_mesi[w] != MESI_I && cur_tag[w] == line_tag) begin
        lk_hit     = 1'b1;
        lk_hit_way = WAY_W'(w);
      end
      if (cur_lru[w] == WAY_W'(WAYS - 1)) lk_lru_way = WAY_W'(w);
    end
    for (int w = 0; w < WAYS; w++) begin
      if (cur_mesi[w] == MESI_I && (!lk_inv_found || cur_lru[w] > lk_best_rank)) begin
        lk_inv_found = 1'b1;
        lk_vict      = WAY_W'(w);
        lk_best_rank = cur_lru[w];
      end
    end
    if (!lk_inv_found) lk_vict = lk_lru_way;
  end

  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx;
  logic [TAG_W-1:0]   new_tag  [WAYS];
  logic [1:0]         new_mesi [WAYS];
  logic [WAY_W-1:0]   new_lru  [WAYS];

  always_comb begin
    wr_en  = 1'b0;
    wr_idx = idx;
    for (int w = 0; w < WAYS; w++) begin
      new_tag[w]  = cur_tag[w];
      new_mesi[w] = cur_mesi[w];
      new_lru[w]  = cur_lru[w];
    end
    if (state_q == SWEEP) begin
      wr_en  = 1'b1;
      wr_idx = sweep_idx_q;
      for (int w = 0; w < WAYS; w++) begin
        new_tag[w]  = '0;
        new_mesi[w] = MESI_I;
        new_lru[w]  = WAY_W'(WAYS - 1 - w);
      end
    end else if (state_q == UPDATE) begin
      if (cmd_q == CMD_READ || cmd_q == CMD_WRITE) begin
        wr_en = 1'b1;
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == way_q) new_lru[w] = '0;
          else if (cur_lru[w] < cur_lru[way_q]) new_lru[w] = cur_lru[w] + 1'b1;
        end
        if (!hit_q) begin
          new_tag[way_q]  = line_tag;
          new_mesi[way_q] = (cmd_q == CMD_READ) ? MESI_E : MESI_M;
        end else if (cmd_q == CMD_WRITE) begin
          new_mesi[way_q] = MESI_M;
        end
      end else if (cmd_q == CMD_INV && hit_q) begin
        wr_en           = 1'b1;
        new_mesi[way_q] = MESI_I;
      end else if (cmd_q == CMD_SNOOP && hit_q) begin
        wr_en           = 1'b1;
        new_mesi[way_q] = MESI_S;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && wr_en) begin
      for (int w = 0; w < WAYS; w++) begin
        tag_arr_q[wr_idx][w]  <= new_tag[w];
        mesi_arr_q[wr_idx][w] <= new_mesi[w];
        lru_arr_q[wr_idx][w]  <= new_lru[w];
      end
    end
  end

  logic               l2_v, rsp_v, rsp_h;
  logic [1:0]         l2_c;
  logic [ADDR_W-1:0]  l2_a;

  always_comb begin
    state_d = state_q;
    l2_v    = 1'b0;
    l2_c    = L2_RETURNDATA;
    l2_a    = '0;
    rsp_v   = 1'b0;
    rsp_h   = 1'b0;
    case (state_q)
      IDLE:   if (cmd_valid) state_d = LOOKUP;
      LOOKUP: state_d = UPDATE;
      UPDATE: begin
        state_d = IDLE;
        case (cmd_q)
          CMD_READ, CMD_WRITE: begin
            if (!hit_q) begin
              l2_v = 1'b1;
              if (vict_dirty_q) begin
                l2_c    = L2_WRITE;
                l2_a    = {vict_tag_q, idx, {OFF_W{1'b0}}};
                state_d = L2_2ND;
              end else begin
                l2_c  = (cmd_q == CMD_READ) ? L2_READ : L2_RFO;
                l2_a  = {line_q, {OFF_W{1'b0}}};
                rsp_v = 1'b1;
              end
            end else begin
              rsp_v = 1'b1;
              rsp_h = 1'b1;
              if (cmd_q == CMD_WRITE && old_mesi_q == MESI_S) begin
                l2_v = 1'b1;
                l2_c = L2_RFO;
                l2_a = {line_q, {OFF_W{1'b0}}};
              end
            end
          end
          CMD_INV, CMD_SNOOP: begin
            rsp_v = 1'b1;
            rsp_h = hit_q;
            if (hit_q && old_mesi_q == MESI_M) begin
              l2_v = 1'b1;
              l2_c = L2_RETURNDATA;
              l2_a = {line_q, {OFF_W{1'b0}}};
            end
          end
          CMD_CLEAR: state_d = SWEEP;
          default:   rsp_v = 1'b1;
        endcase
      end
      L2_2ND: begin
        state_d = IDLE;
        l2_v    = 1'b1;
        l2_c    = (cmd_q == CMD_READ) ? L2_READ : L2_RFO;
        l2_a    = {line_q, {OFF_W{1'b0}}};
        rsp_v   = 1'b1;
      end
      SWEEP: begin
        if (sweep_idx_q == IDX_W'(SETS - 1)) begin
          state_d = IDLE;
          rsp_v   = clear_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= SWEEP;
      sweep_idx_q  <= '0;
      clear_q      <= 1'b0;
      cmd_q        <= '0;
      line_q       <= '0;
      hit_q        <= 1'b0;
      vict_dirty_q <= 1'b0;
      way_q        <= '0;
      old_mesi_q   <= MESI_I;
      vict_tag_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && cmd_valid) begin
        cmd_q  <= cmd;
        line_q <= addr[ADDR_W-1:OFF_W];
      end
      if (state_q == LOOKUP) begin
        hit_q        <= lk_hit;
        way_q        <= lk_hit ? lk_hit_way : lk_vict;
        old_mesi_q   <= cur_mesi[lk_hit_way];
        vict_tag_q   <= cur_tag[lk_vict];
        vict_dirty_q <= !lk_hit && (cur_mesi[lk_vict] == MESI_M);
      end
      if (state_q == UPDATE && cmd_q == CMD_CLEAR) begin
        sweep_idx_q <= '0;
        clear_q     <= 1'b1;
      end
      if (state_q == SWEEP) sweep_idx_q <= sweep_idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dump_line_q <= '0;
    end else if (int'(dump_way) < WAYS) begin
      dump_line_q <= {tag_arr_q[dump_set][dump_way[WAY_W-1:0]],
                      mesi_arr_q[dump_set][dump_way[WAY_W-1:0]],
                      4'(lru_arr_q[dump_set][dump_way[WAY_W-1:0]])};
    end else begin
      dump_line_q <= '0;
    end
  end

  // Outputs are forced low combinationally so they read zero for the whole time rst is low.
  assign cmd_ready  = rst && (state_q == IDLE);
  assign l2_valid   = rst && l2_v;
  assign l2_cmd     = rst ? l2_c : 2'd0;
  assign l2_addr    = rst ? l2_a : '0;
  assign resp_valid = rst && rsp_v;
  assign resp_hit   = rst && rsp_h;
  assign dump_line  = dump_line_q;

`ifdef CACHE_STATS_EN
  logic [31:0] hits_q, misses_q, reads_q, writes_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      hits_q   <= '0;
      misses_q <= '0;
      reads_q  <= '0;
      writes_q <= '0;
    end else if (state_q == UPDATE) begin
      if (cmd_q == CMD_CLEAR) begin
        hits_q   <= '0;
        misses_q <= '0;
        reads_q  <= '0;
        writes_q <= '0;
      end else if (cmd_q == CMD_READ || cmd_q == CMD_WRITE) begin
        if (hit_q) hits_q <= hits_q + 32'd1;
        else       misses_q <= misses_q + 32'd1;
        if (cmd_q == CMD_READ) reads_q <= reads_q + 32'd1;
        else                   writes_q <= writes_q + 32'd1;
      end
    end
  end

  assign hits   = hits_q;
  assign misses = misses_q;
  assign reads  = reads_q;
  assign writes = writes_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_datacache_l1_param.sv
`default_nettype none
// tb_datacache_l1_param: scoreboard bench for datacache_l1_param (WAYS=4, SETS=16, ADDR_W=32).
module tb_datacache_l1_param;

  localparam int WAYS   = 4;
  localparam int SETS   = 16;
  localparam int ADDR_W = 32;

  localparam logic [2:0] C_RD = 3'd0, C_WR = 3'd1, C_INV = 3'd2, C_CLR = 3'd3, C_SNP = 3'd4;
  localparam logic [1:0] L_RD_DATA = 2'd0, L_WRITE = 2'd1, L_READ = 2'd2, L_RFO = 2'd3;
  localparam logic [1:0] M_I = 2'd0, M_M = 2'd1, M_S = 2'd2, M_E = 2'd3;

  logic        clk, rst, cmd_valid, cmd_ready;
  logic [2:0]  cmd;
  logic [31:0] addr;
  logic        l2_valid;
  logic [1:0]  l2_cmd;
  logic [31:0] l2_addr;
  logic        resp_valid, resp_hit;
  logic [3:0]  dump_set, dump_way;
  logic [27:0] dump_line;
`ifdef CACHE_STATS_EN
  logic [31:0] hits, misses, reads, writes;
`endif

  datacache_l1_param #(.WAYS(WAYS), .SETS(SETS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd), .addr(addr),
    .l2_valid(l2_valid), .l2_cmd(l2_cmd), .l2_addr(l2_addr),
    .resp_valid(resp_valid), .resp_hit(resp_hit),
    .dump_set(dump_set), .dump_way(dump_way), .dump_line(dump_line)
`ifdef CACHE_STATS_EN
    , .hits(hits), .misses(misses), .reads(reads), .writes(writes)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int          cyc;
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic        hit;
  } exp_t;

  exp_t l2_exp[$];
  exp_t resp_exp[$];
  exp_t mon_e;
  logic mon_en = 1'b0;

  // Reference model of the cache contents and counters.
  logic [21:0] m_tag  [SETS][WAYS];
  logic [1:0]  m_mesi [SETS][WAYS];
  int          m_lru  [SETS][WAYS];
  int          m_hits, m_misses, m_reads, m_writes;

  task automatic push_l2(input int c, input logic [1:0] k, input logic [31:0] a);
    exp_t e;
    e.cyc = c; e.cmd = k; e.addr = a; e.hit = 1'b0;
    l2_exp.push_back(e);
  endtask

  task automatic push_resp(input int c, input logic h);
    exp_t e;
    e.cyc = c; e.cmd = 2'd0; e.addr = '0; e.hit = h;
    resp_exp.push_back(e);
  endtask

  task automatic model_sweep();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_tag[s][w] = '0; m_mesi[s][w] = M_I; m_lru[s][w] = WAYS - 1 - w;
      end
    m_hits = 0; m_misses = 0; m_reads = 0; m_writes = 0;
  endtask

  task automatic model_touch(input int s, input int w);
    int r;
    r = m_lru[s][w];
    for (int j = 0; j < WAYS; j++)
      if (j == w) m_lru[s][j] = 0;
      else if (m_lru[s][j] < r) m_lru[s][j]++;
  endtask

  task automatic model_cmd(input logic [2:0] c, input logic [31:0] a, input int acc);
    int s, hw, v;
    logic [21:0] t;
    logic [31:0] la;
    logic [1:0]  fill;
    s = int'(a[9:6]); t = a[31:10]; la = {a[31:6], 6'd0}; hw = -1; v = -1;
    for (int w = 0; w < WAYS; w++)
      if (hw < 0 && m_mesi[s][w] != M_I && m_tag[s][w] == t) hw = w;
    case (c)
      C_RD, C_WR: begin
        if (c == C_RD) m_reads++; else m_writes++;
        if (hw >= 0) begin
          m_hits++;
          if (c == C_WR) begin
            if (m_mesi[s][hw] == M_S) push_l2(acc + 2, L_RFO, la);
            m_mesi[s][hw] = M_M;
          end
          model_touch(s, hw);
          push_resp(acc + 2, 1'b1);
        end else begin
          m_misses++;
          for (int w = 0; w < WAYS; w++)
            if (m_mesi[s][w] == M_I && (v < 0 || m_lru[s][w] > m_lru[s][v])) v = w;
          if (v < 0)
            for (int w = 0; w < WAYS; w++)
              if (v < 0 && m_lru[s][w] == WAYS - 1) v = w;
          fill = (c == C_RD) ? L_READ : L_RFO;
          if (m_mesi[s][v] == M_M) begin
            push_l2(acc + 2, L_WRITE, {m_tag[s][v], a[9:6], 6'd0});
            push_l2(acc + 3, fill, la);
            push_resp(acc + 3, 1'b0);
          end else begin
            push_l2(acc + 2, fill, la);
            push_resp(acc + 2, 1'b0);
          end
          m_tag[s][v]  = t;
          m_mesi[s][v] = (c == C_RD) ? M_E : M_M;
          model_touch(s, v);
        end
      end
      C_INV: begin
        if (hw >= 0) begin
          if (m_mesi[s][hw] == M_M) push_l2(acc + 2, L_RD_DATA, la);
          m_mesi[s][hw] = M_I;
        end
        push_resp(acc + 2, hw >= 0);
      end
      C_SNP: begin
        if (hw >= 0) begin
          if (m_mesi[s][hw] == M_M) push_l2(acc + 2, L_RD_DATA, la);
          m_mesi[s][hw] = M_S;
        end
        push_resp(acc + 2, hw >= 0);
      end
      C_CLR: begin
        model_sweep();
        push_resp(acc + 2 + SETS, 1'b0);
      end
      default: push_resp(acc + 2, 1'b0);
    endcase
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (l2_valid) begin
        if (l2_exp.size() == 0) check("l2_unexpected", 64'(l2_valid), 64'd0);
        else begin
          mon_e = l2_exp.pop_front();
          check("l2_cycle", 64'(cyc), 64'(mon_e.cyc));
          check("l2_cmd", 64'(l2_cmd), 64'(mon_e.cmd));
          check("l2_addr", 64'(l2_addr), 64'(mon_e.addr));
        end
      end else if (l2_exp.size() != 0 && l2_exp[0].cyc <= cyc) begin
        mon_e = l2_exp.pop_front();
        check("l2_missing", 64'(l2_valid), 64'd1);
      end
      if (resp_valid) begin
        if (resp_exp.size() == 0) check("resp_unexpected", 64'(resp_valid), 64'd0);
        else begin
          mon_e = resp_exp.pop_front();
          check("resp_cycle", 64'(cyc), 64'(mon_e.cyc));
          check("resp_hit", 64'(resp_hit), 64'(mon_e.hit));
        end
      end else if (resp_exp.size() != 0 && resp_exp[0].cyc <= cyc) begin
        mon_e = resp_exp.pop_front();
        check("resp_missing", 64'(resp_valid), 64'd1);
      end
    end
  end

  task automatic wait_done();
    int n;
    n = 0;
    while ((l2_exp.size() != 0 || resp_exp.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (l2_exp.size() != 0 || resp_exp.size() != 0) begin
      check("done_timeout", 64'(l2_exp.size() + resp_exp.size()), 64'd0);
      l2_exp.delete();
      resp_exp.delete();
    end
  endtask

  task automatic issue(input logic [2:0] c, input logic [31:0] a);
    int n;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check("ready_timeout", 64'(cmd_ready), 64'd1);
      return;
    end
    cmd_valid = 1'b1; cmd = c; addr = a;
    model_cmd(c, a, cyc);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_done();
  endtask

  task automatic dump_chk(input string tag, input int s, input int w);
    logic [27:0] e;
    dump_set = 4'(s); dump_way = 4'(w);
    @(negedge clk);
    if (w < WAYS) e = {m_tag[s][w], m_mesi[s][w], 4'(m_lru[s][w])};
    else          e = '0;
    check(tag, 64'(dump_line), 64'(e));
  endtask

  function automatic logic [31:0] mk(input int tag, input int set, input int off);
    return {22'(tag), 4'(set), 6'(off)};
  endfunction

`ifdef CACHE_STATS_EN
  task automatic stats_chk(input string tag);
    check({tag, "_hits"}, 64'(hits), 64'(m_hits));
    check({tag, "_misses"}, 64'(misses), 64'(m_misses));
    check({tag, "_reads"}, 64'(reads), 64'(m_reads));
    check({tag, "_writes"}, 64'(writes), 64'(m_writes));
  endtask
`endif

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    logic [2:0] c;
    rst = 1'b0; cmd_valid = 1'b1; cmd = C_RD; addr = '0; dump_set = '0; dump_way = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(cmd_ready), 64'd0);
    check("rst_l2_valid", 64'(l2_valid), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_l2_addr", 64'(l2_addr), 64'd0);
    check("rst_dump", 64'(dump_line), 64'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst2_ready", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;
    model_sweep();
    n = 0;
    while (!cmd_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("sweep_cycles", 64'(n), 64'd16);

    dump_chk("dump_s5w0", 5, 0);
    dump_chk("dump_s15w3", 15, 3);
    dump_chk("dump_way_oob", 5, 7);

    // Cold miss then hit on the same line.
    issue(C_RD, 32'h1040);
    dump_chk("r1_way0", 1, 0);
    check("r1_way0_E", 64'(dump_line[5:4]), 64'(M_E));
    issue(C_RD, 32'h1040);
    dump_chk("r2_way0", 1, 0);

    // Fill set 1 with dirty lines, then force a dirty eviction.
    issue(C_CLR, 32'h0);
    for (int t = 1; t <= 4; t++) issue(C_WR, mk(t, 1, 0));
    for (int w = 0; w < WAYS; w++) dump_chk("fill_set1", 1, w);
    issue(C_RD, mk(5, 1, 12));
    for (int w = 0; w < WAYS; w++) dump_chk("evict_set1", 1, w);

    // MESI walk E -> S -> M -> I on one line.
    issue(C_CLR, 32'h0);
    issue(C_RD, mk(2, 1, 0));
    issue(C_RD, mk(2, 1, 0));
    issue(C_SNP, mk(2, 1, 0));
    dump_chk("snoop_S", 1, 0);
    issue(C_WR, mk(2, 1, 0));
    dump_chk("write_M", 1, 0);
    issue(C_INV, mk(2, 1, 0));
    dump_chk("inv_I", 1, 0);
    issue(C_INV, mk(2, 1, 0));
    issue(C_SNP, mk(3, 1, 0));

    for (int i = 0; i < 80; i++) begin
      k = $urandom_range(0, 9);
      c = (k < 4) ? C_RD : (k < 7) ? C_WR : (k < 8) ? C_INV : C_SNP;
      issue(c, mk($urandom_range(0, 5), $urandom_range(0, 2), $urandom_range(0, 63)));
    end
    for (int s = 0; s < 3; s++)
      for (int w = 0; w < WAYS; w++) dump_chk("rand_dump", s, w);
`ifdef CACHE_STATS_EN
    stats_chk("stats_rand");
`endif

    issue(C_CLR, 32'h0);
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) dump_chk("clear_dump", s, w);
`ifdef CACHE_STATS_EN
    stats_chk("stats_clear");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
